// File: rtl/ss_pkg.sv
// Shared types and constants for the serial frame receiver.
// Optional SS_PARITY_EN build adds the PARITY state.
package ss_pkg;

  typedef enum logic [1:0] {
    SS_IDLE,
    SS_DATA,
    SS_PARITY,
    SS_STOP
  } ss_rx_state_t;

  localparam int   SS_DEFAULT_WIDTH = 8;
  localparam logic SS_IDLE_LEVEL    = 1'b1;
  localparam logic SS_START_LEVEL   = 1'b0;

endpackage

// File: rtl/ss_rx_shifter.sv
// Direction-selectable shift register for incoming serial bits.
// LSB-first shifts right (bit enters MSB); MSB-first shifts left.
module ss_rx_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_lsb_first,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      if (i_lsb_first) begin
        r_q <= {i_bit, r_q[WIDTH-1:1]};
      end else begin
        r_q <= {r_q[WIDTH-2:0], i_bit};
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ss_frame_receiver.sv
// Serial start/data/stop frame receiver with valid/ready output.
// Define SS_PARITY_EN for an even-parity bit and parity_err pulse.
module ss_frame_receiver
  import ss_pkg::*;
#(
  parameter int WIDTH = SS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             ser_in,
  input  logic             leri,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             framing_err,
  output logic             overrun
`ifdef SS_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH);

  ss_rx_state_t     r_state;
  ss_rx_state_t     w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_leri;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;
  logic             w_start;
  logic             w_shift;
  logic             w_stop;
  logic             w_good;
  logic             w_bad;
  logic             w_take;
  logic             w_load;
  logic [WIDTH-1:0] w_q;
`ifdef SS_PARITY_EN
  logic             r_par;
  logic             r_perr;
`endif

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_shift = 1'b0;
    w_stop  = 1'b0;
    if (ena) begin
      unique case (r_state)
        SS_IDLE: begin
          if (ser_in == SS_START_LEVEL) begin
            w_start = 1'b1;
            w_next  = SS_DATA;
          end
        end
        SS_DATA: begin
          w_shift = 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef SS_PARITY_EN
            w_next = SS_PARITY;
`else
            w_next = SS_STOP;
`endif
          end
        end
`ifdef SS_PARITY_EN
        SS_PARITY: w_next = SS_STOP;
`endif
        SS_STOP: begin
          w_stop = 1'b1;
          w_next = SS_IDLE;
        end
        default: w_next = SS_IDLE;
      endcase
    end
  end

  assign w_good = w_stop & (ser_in == SS_IDLE_LEVEL);
  assign w_bad  = w_stop & (ser_in != SS_IDLE_LEVEL);
  assign w_take = r_valid & data_ready;
  // A new word may replace the old one only if it leaves this edge
  assign w_load = w_good & (~r_valid | w_take);

  ss_rx_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_shift),
    .i_lsb_first(r_leri),
    .i_bit      (ser_in),
    .o_q        (w_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SS_IDLE;
      r_cnt   <= '0;
      r_leri  <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ferr  <= w_bad;
      if (w_start) begin
        r_leri <= leri;
        r_cnt  <= '0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_load) begin
        r_data  <= w_q;
        r_valid <= 1'b1;
      end else if (w_take) begin
        r_valid <= 1'b0;
      end
      if (w_good & ~w_load) begin
        r_ovr <= 1'b1;
      end
    end
  end

`ifdef SS_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (ena && r_state == SS_PARITY) begin
        r_par <= ser_in;
      end
      r_perr <= w_stop & ((^w_q) ^ r_par);
    end
  end

  assign parity_err = r_perr;
`endif

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign busy        = (r_state != SS_IDLE);
  assign framing_err = r_ferr;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_ss_frame_receiver.sv
// Randomized bench for ss_frame_receiver against a frame-level model.
// Honours SS_PARITY_EN when the design is built with it.
module tb_ss_frame_receiver;

  localparam int W = 8;
`ifdef SS_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic         ser_in = 1'b1;
  logic         leri = 1'b1;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         framing_err;
  logic         overrun;
`ifdef SS_PARITY_EN
  logic         parity_err;
`endif

  int checks = 0;
  int failures = 0;
  bit rnd_ready = 1'b0;

  always #5 clk = ~clk;

  ss_frame_receiver #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .ser_in     (ser_in),
    .leri       (leri),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .framing_err(framing_err),
    .overrun    (overrun)
`ifdef SS_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: collects sampled bits into a queue and
  // assembles the word arithmetically once the stop bit arrives.
  logic [W-1:0] m_data = '0;
  logic         m_valid = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_ferr = 1'b0;
  logic         m_perr = 1'b0;
  logic         m_ovr = 1'b0;
  bit           m_in = 1'b0;
  bit           m_leri = 1'b0;
  bit           m_q[$];

  always @(posedge clk) begin
    logic [W-1:0] word;
    bit good;
    bit take;
    if (!rst_n) begin
      m_data = '0; m_valid = 0; m_busy = 0;
      m_ferr = 0; m_perr = 0; m_ovr = 0;
      m_in = 0; m_q.delete();
    end else begin
      take = m_valid && data_ready;
      good = 0;
      word = '0;
      m_ferr = 0;
      m_perr = 0;
      if (ena) begin
        if (!m_in) begin
          if (ser_in == 1'b0) begin
            m_in = 1; m_leri = leri; m_q.delete();
          end
        end else if (m_q.size() < NB) begin
          m_q.push_back(ser_in);
        end else begin
          for (int i = 0; i < W; i++) begin
            if (m_leri) word[i] = m_q[i];
            else word[W-1-i] = m_q[i];
          end
          m_in = 0;
          if (ser_in) good = 1;
          else m_ferr = 1;
`ifdef SS_PARITY_EN
          m_perr = (^word) ^ m_q[W];
`endif
        end
      end
      if (good && (!m_valid || take)) begin
        m_data = word; m_valid = 1;
      end else begin
        if (good) m_ovr = 1;
        if (take) m_valid = 0;
      end
      m_busy = m_in;
    end
  end

  always @(negedge clk) begin
    chk("data_valid", 32'(data_valid), 32'(m_valid));
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("framing_err", 32'(framing_err), 32'(m_ferr));
    chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef SS_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
  end

  task automatic step(input logic e, input logic s);
    ena = e;
    ser_in = s;
    if (rnd_ready) data_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit lsb,
                            input bit stop_ok, input bit par_ok,
                            input int gap);
    bit b[$];
    int n;
    b.push_back(1'b0);
    for (int i = 0; i < W; i++) b.push_back(lsb ? w[i] : w[W-1-i]);
`ifdef SS_PARITY_EN
    b.push_back(par_ok ? (^w) : ~(^w));
`endif
    b.push_back(stop_ok);
    foreach (b[k]) begin
      n = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (n) step(1'b0, 1'($urandom_range(0, 1)));
      leri = (k == 0) ? lsb : 1'($urandom_range(0, 1));
      step(1'b1, b[k]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) step(1'b1, 1'b1);
    rst_n = 1'b1;
    chk("rst data_out", 32'(data_out), 32'h0);
    chk("rst data_valid", 32'(data_valid), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst overrun", 32'(overrun), 32'h0);
    step(1'b1, 1'b1);

    data_ready = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 0);
    chk("lsb A5 word", 32'(data_out), 32'hA5);
    chk("lsb A5 valid", 32'(data_valid), 32'h1);
    chk("lsb A5 ferr", 32'(framing_err), 32'h0);
    data_ready = 1'b1;
    step(1'b1, 1'b1);
    chk("A5 consumed", 32'(data_valid), 32'h0);

    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 0);
    chk("msb 3C word", 32'(data_out), 32'h3C);
    chk("msb 3C valid", 32'(data_valid), 32'h1);
    step(1'b1, 1'b1);
    chk("3C one cycle", 32'(data_valid), 32'h0);

    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, 1'b1, 0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1, 0);
    chk("ovr keeps 11", 32'(data_out), 32'h11);
    chk("ovr flag", 32'(overrun), 32'h1);
    data_ready = 1'b1;
    step(1'b1, 1'b1);
    chk("ovr consumed", 32'(data_valid), 32'h0);
    chk("ovr sticky", 32'(overrun), 32'h1);

    data_ready = 1'b0;
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 0);
    chk("ferr pulse", 32'(framing_err), 32'h1);
    chk("ferr no valid", 32'(data_valid), 32'h0);
    step(1'b1, 1'b1);
    chk("ferr one cycle", 32'(framing_err), 32'h0);
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 0);
    chk("after ferr 0F", 32'(data_out), 32'h0F);
    data_ready = 1'b1;
    step(1'b1, 1'b1);

    send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1);
    chk("gaps C3 word", 32'(data_out), 32'hC3);
    chk("gaps C3 valid", 32'(data_valid), 32'h1);
    step(1'b1, 1'b1);

    data_ready = 1'b0;
    leri = 1'b1;
    step(1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b1);
    rst_n = 1'b0;
    step(1'b1, 1'b1);
    rst_n = 1'b1;
    chk("midrst busy", 32'(busy), 32'h0);
    chk("midrst overrun", 32'(overrun), 32'h0);
    chk("midrst data_out", 32'(data_out), 32'h0);
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, 0);
    chk("post rst 81", 32'(data_out), 32'h81);
`ifdef SS_PARITY_EN
    data_ready = 1'b1;
    step(1'b1, 1'b1);
    data_ready = 1'b0;
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 0);
    chk("par err pulse", 32'(parity_err), 32'h1);
    chk("par err word", 32'(data_out), 32'h81);
`endif

    rnd_ready = 1'b1;
    repeat (400) begin
      repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b1);
      send_frame(W'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)));
    end
    rnd_ready = 1'b0;
    repeat (3) step(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
